control_status_register_file: RTL and testbench
===============================================

CONTROL_STATUS_REGISTER_FILE -- requirements
Module: control_status_register_file

Interface
REQ-001 The block SHALL have parameter HART_ID, default 32'h0000_0000, meaning the value returned by mhartid.
REQ-002 The block SHALL have parameter MISA_VALUE, default 32'h4000_0100, meaning the value returned by misa (RV32I).
REQ-003 The block SHALL have port clk  input  1  rising-edge clock for all state.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-low reset sampled on rising clk.
REQ-005 The block SHALL have port read_enable  input  1  CSR read request.
REQ-006 The block SHALL have port write_enable  input  1  CSR write request.
REQ-007 The block SHALL have port csr_address  input  12  CSR index shared by read and write.
REQ-008 The block SHALL have port csr_write_data  input  32  new CSR value (CSR_out from the CSR operation stage).
REQ-009 The block SHALL have port instret_increment  input  1  one instruction retired this cycle.
REQ-010 The block SHALL have port csr_read_data  output  32  current CSR value (CSR_in of the CSR operation stage).
REQ-011 The block SHALL have port illegal_access  output  1  access to an unmapped CSR, or write to a read-only CSR.

Function
REQ-012 Implemented CSRs SHALL be: mstatus 0x300, misa 0x301, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343, mcycle/mcycleh 0xB00/0xB80, minstret/minstreth 0xB02/0xB82, cycle/cycleh 0xC00/0xC80, instret/instreth 0xC02/0xC82, mhartid 0xF14.
REQ-013 Reads SHALL be combinational: csr_read_data reflects register state before any same-cycle write (read-before-write).
REQ-014 csr_read_data SHALL be 32'h0 when read_enable=0 or csr_address is unmapped.
REQ-015 Writes SHALL commit on the rising clk edge when write_enable=1 and reset=1.
REQ-016 csr_address[11:10]=2'b11 (0xC00-0xC82, 0xF14) SHALL be read-only; misa SHALL ignore writes without flagging illegal.
REQ-017 illegal_access SHALL be combinational, asserted when (read_enable|write_enable) and the address is unmapped, or write_enable and csr_address[11:10]=2'b11; such writes SHALL change no state.
REQ-018 mstatus SHALL store only bit 3 (MIE) and bit 7 (MPIE); bits 12:11 (MPP) SHALL read 2'b11; all other bits SHALL read 0.
REQ-019 mepc SHALL force bit 0 to 0 on write; mie, mtvec, mscratch, mcause, mtval SHALL store all 32 bits.
REQ-020 mcycle SHALL be a 64-bit counter incrementing by 1 every cycle reset is deasserted.
REQ-021 minstret SHALL be a 64-bit counter incrementing by 1 in cycles where instret_increment=1.
REQ-022 Counter carry SHALL propagate from low to high word; 64'hFFFF_FFFF_FFFF_FFFF +1 SHALL wrap to 0.
REQ-023 A write to a counter half SHALL take priority over that cycle's increment: written half takes csr_write_data exactly, the other half holds (no carry).
REQ-024 cycle/cycleh and instret/instreth SHALL be read-only aliases of mcycle/mcycleh and minstret/minstreth.
REQ-025 read_enable and write_enable SHALL be independent; both high on one address SHALL return the old value and commit the new one.

Reset
REQ-026 When reset=0 at a rising clk edge, all writable CSRs and both counters SHALL become 0, overriding any write or increment that cycle.
REQ-027 Reset asserted mid-operation SHALL take effect at the next clk edge only; outputs remain combinational from current state until then.
REQ-028 The first increment after reset release SHALL occur on the first clk edge with reset=1 (mcycle=1 after that edge).

Verification
REQ-029 Reset then 10 idle cycles, read 0xB00 -> 32'd10; read 0xB80 -> 0.
REQ-030 Write 0xB00=32'hFFFF_FFFF, then one idle cycle -> 0xB00 reads 0, 0xB80 reads 1.
REQ-031 Write 0x341=32'h8000_0003, read -> 32'h8000_0002; write 0x300=32'hFFFF_FFFF, read -> 32'h0000_1888.
REQ-032 Write 0xC00=32'h1234 -> illegal_access=1 that cycle, cycle count unchanged by write; read 0x7FF -> illegal_access=1, data 0.
REQ-033 read+write 0x340=32'hA5A5_A5A5 same cycle from 0 -> read data 0; next cycle read -> 32'hA5A5_A5A5.
REQ-034 instret_increment=1 for 5 cycles with write to 0xB02=32'd100 on cycle 3 -> 0xB02 reads 32'd102 afterward; reset=0 one cycle -> all reads 0 except misa, mhartid, mstatus MPP.

Source files
------------

// File: rtl/control_status_register_file.sv
// Machine-mode CSR file: scratch/trap registers, a reduced mstatus, and the
// 64-bit mcycle/minstret counters with their read-only user aliases.
module control_status_register_file #(
   parameter logic [31:0] HART_ID    = 32'h0000_0000,
   parameter logic [31:0] MISA_VALUE = 32'h4000_0100
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        read_enable,
   input  logic        write_enable,
   input  logic [11:0] csr_address,
   input  logic [31:0] csr_write_data,
   input  logic        instret_increment,
   output logic [31:0] csr_read_data,
   output logic        illegal_access
);

   localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
   localparam logic [11:0] ADDR_MISA      = 12'h301;
   localparam logic [11:0] ADDR_MIE       = 12'h304;
   localparam logic [11:0] ADDR_MTVEC     = 12'h305;
   localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
   localparam logic [11:0] ADDR_MEPC      = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
   localparam logic [11:0] ADDR_MTVAL     = 12'h343;
   localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
   localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
   localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
   localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
   localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
   localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;
   localparam logic [11:0] ADDR_INSTRETH  = 12'hC82;
   localparam logic [11:0] ADDR_MHARTID   = 12'hF14;

   logic        mstatus_mie_q, mstatus_mie_d;
   logic        mstatus_mpie_q, mstatus_mpie_d;
   logic [31:0] mie_q, mie_d;
   logic [31:0] mtvec_q, mtvec_d;
   logic [31:0] mscratch_q, mscratch_d;
   logic [31:0] mepc_q, mepc_d;
   logic [31:0] mcause_q, mcause_d;
   logic [31:0] mtval_q, mtval_d;
   logic [63:0] mcycle_q, mcycle_d;
   logic [63:0] minstret_q, minstret_d;

   logic        addr_mapped;
   logic        addr_read_only;
   logic        write_commit;
   logic [31:0] read_value;

   always_comb begin
      addr_mapped = 1'b1;
      read_value  = '0;
      case (csr_address)
         ADDR_MSTATUS:               read_value = {19'b0, 2'b11, 3'b0, mstatus_mpie_q,
                                                   3'b0, mstatus_mie_q, 3'b0};
         ADDR_MISA:                  read_value = MISA_VALUE;
         ADDR_MIE:                   read_value = mie_q;
         ADDR_MTVEC:                 read_value = mtvec_q;
         ADDR_MSCRATCH:              read_value = mscratch_q;
         ADDR_MEPC:                  read_value = mepc_q;
         ADDR_MCAUSE:                read_value = mcause_q;
         ADDR_MTVAL:                 read_value = mtval_q;
         ADDR_MCYCLE,   ADDR_CYCLE:    read_value = mcycle_q[31:0];
         ADDR_MCYCLEH,  ADDR_CYCLEH:   read_value = mcycle_q[63:32];
         ADDR_MINSTRET, ADDR_INSTRET:  read_value = minstret_q[31:0];
         ADDR_MINSTRETH, ADDR_INSTRETH: read_value = minstret_q[63:32];
         ADDR_MHARTID:               read_value = HART_ID;
         default:                    addr_mapped = 1'b0;
      endcase
   end

   // The 0xCxx/0xFxx space is read-only; writes there are flagged and dropped.
   assign addr_read_only = (csr_address[11:10] == 2'b11);
   assign write_commit   = write_enable & addr_mapped & ~addr_read_only;
   assign illegal_access = ((read_enable | write_enable) & ~addr_mapped)
                         | (write_enable & addr_read_only);
   assign csr_read_data  = read_enable ? read_value : 32'h0;

   always_comb begin
      mstatus_mie_d  = mstatus_mie_q;
      mstatus_mpie_d = mstatus_mpie_q;
      mie_d          = mie_q;
      mtvec_d        = mtvec_q;
      mscratch_d     = mscratch_q;
      mepc_d         = mepc_q;
      mcause_d       = mcause_q;
      mtval_d        = mtval_q;
      mcycle_d       = mcycle_q + 64'd1;
      minstret_d     = minstret_q + {63'b0, instret_increment};
      if (write_commit) begin
         // A counter-half write replaces that cycle's increment entirely.
         case (csr_address)
            ADDR_MSTATUS: begin
               mstatus_mie_d  = csr_write_data[3];
               mstatus_mpie_d = csr_write_data[7];
            end
            ADDR_MIE:       mie_d      = csr_write_data;
            ADDR_MTVEC:     mtvec_d    = csr_write_data;
            ADDR_MSCRATCH:  mscratch_d = csr_write_data;
            ADDR_MEPC:      mepc_d     = {csr_write_data[31:1], 1'b0};
            ADDR_MCAUSE:    mcause_d   = csr_write_data;
            ADDR_MTVAL:     mtval_d    = csr_write_data;
            ADDR_MCYCLE:    mcycle_d   = {mcycle_q[63:32], csr_write_data};
            ADDR_MCYCLEH:   mcycle_d   = {csr_write_data, mcycle_q[31:0]};
            ADDR_MINSTRET:  minstret_d = {minstret_q[63:32], csr_write_data};
            ADDR_MINSTRETH: minstret_d = {csr_write_data, minstret_q[31:0]};
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         mstatus_mie_q  <= 1'b0;
         mstatus_mpie_q <= 1'b0;
         mie_q          <= '0;
         mtvec_q        <= '0;
         mscratch_q     <= '0;
         mepc_q         <= '0;
         mcause_q       <= '0;
         mtval_q        <= '0;
         mcycle_q       <= '0;
         minstret_q     <= '0;
      end else begin
         mstatus_mie_q  <= mstatus_mie_d;
         mstatus_mpie_q <= mstatus_mpie_d;
         mie_q          <= mie_d;
         mtvec_q        <= mtvec_d;
         mscratch_q     <= mscratch_d;
         mepc_q         <= mepc_d;
         mcause_q       <= mcause_d;
         mtval_q        <= mtval_d;
         mcycle_q       <= mcycle_d;
         minstret_q     <= minstret_d;
      end
   end

endmodule

// File: tb/tb_control_status_register_file.sv
// Bench for control_status_register_file: per-cycle comparison against a
// behavioural CSR model, plus hand-computed checks of key scenarios.
module tb_control_status_register_file;

   localparam logic [31:0] MISA = 32'h4000_0100;
   localparam logic [31:0] HART = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        read_enable = 1'b0;
   logic        write_enable = 1'b0;
   logic [11:0] csr_address = '0;
   logic [31:0] csr_write_data = '0;
   logic        instret_increment = 1'b0;
   logic [31:0] csr_read_data;
   logic        illegal_access;

   int total = 0;
   int bad = 0;
   bit check_en = 1'b0;

   // Model state: plain storage indexed by CSR address, counters as 64-bit ints.
   logic [31:0]     m_reg [0:4095];
   longint unsigned m_cycle = 0;
   longint unsigned m_instret = 0;

   control_status_register_file dut (
      .clk               (clk),
      .reset             (reset),
      .read_enable       (read_enable),
      .write_enable      (write_enable),
      .csr_address       (csr_address),
      .csr_write_data    (csr_write_data),
      .instret_increment (instret_increment),
      .csr_read_data     (csr_read_data),
      .illegal_access    (illegal_access)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic model_read(input logic [11:0] a, output logic [31:0] d, output bit mapped);
      mapped = 1'b1;
      d      = 32'h0;
      case (a)
         12'h300:                   d = (m_reg[12'h300] & 32'h88) | 32'h1800;
         12'h301:                   d = MISA;
         12'h304, 12'h305, 12'h340,
         12'h341, 12'h342, 12'h343: d = m_reg[a];
         12'hB00, 12'hC00:          d = m_cycle[31:0];
         12'hB80, 12'hC80:          d = m_cycle[63:32];
         12'hB02, 12'hC02:          d = m_instret[31:0];
         12'hB82, 12'hC82:          d = m_instret[63:32];
         12'hF14:                   d = HART;
         default:                   mapped = 1'b0;
      endcase
   endtask

   task automatic model_step();
      longint unsigned nc, ni;
      logic [31:0] d;
      bit mapped;
      if (!reset) begin
         m_cycle   = 0;
         m_instret = 0;
         foreach (m_reg[i]) m_reg[i] = 32'h0;
         return;
      end
      nc = m_cycle + 1;
      ni = m_instret + (instret_increment ? 1 : 0);
      model_read(csr_address, d, mapped);
      if (write_enable && mapped && csr_address[11:10] != 2'b11) begin
         case (csr_address)
            12'h300: m_reg[12'h300] = csr_write_data & 32'h88;
            12'h341: m_reg[12'h341] = csr_write_data & 32'hFFFF_FFFE;
            12'h304, 12'h305, 12'h340, 12'h342, 12'h343:
                     m_reg[csr_address] = csr_write_data;
            12'hB00: nc = (m_cycle & 64'hFFFF_FFFF_0000_0000) | csr_write_data;
            12'hB80: nc = (m_cycle & 64'h0000_0000_FFFF_FFFF) | (longint'(csr_write_data) << 32);
            12'hB02: ni = (m_instret & 64'hFFFF_FFFF_0000_0000) | csr_write_data;
            12'hB82: ni = (m_instret & 64'h0000_0000_FFFF_FFFF) | (longint'(csr_write_data) << 32);
            default: ;
         endcase
      end
      m_cycle   = nc;
      m_instret = ni;
   endtask

   initial begin
      foreach (m_reg[i]) m_reg[i] = 32'h0;
      forever begin
         @(posedge clk);
         model_step();
      end
   end

   initial begin
      logic [31:0] d;
      bit mapped;
      forever begin
         @(negedge clk);
         if (check_en) begin
            model_read(csr_address, d, mapped);
            check("model_rdata", csr_read_data, (read_enable && mapped) ? d : 32'h0);
            check("model_illegal", {31'b0, illegal_access},
                  {31'b0, ((read_enable || write_enable) && !mapped) ||
                          (write_enable && csr_address[11:10] == 2'b11)});
         end
      end
   end

   task automatic drive(input logic rst, input logic re, input logic we,
                        input logic [11:0] a, input logic [31:0] wd, input logic inc);
      reset             = rst;
      read_enable       = re;
      write_enable      = we;
      csr_address       = a;
      csr_write_data    = wd;
      instret_increment = inc;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic peek();
      @(negedge clk);
      #1;
   endtask

   logic [11:0] seq_addr [0:11] = '{12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                                    12'h300, 12'hB82, 12'hB02, 12'hF14, 12'hC82, 12'h123};
   logic [31:0] seq_data [0:11] = '{32'h1234_5678, 32'h8000_0101, 32'hDEAD_BEEF, 32'h0000_0FFF,
                                    32'h8000_000B, 32'hCAFE_F00D, 32'h0000_0080, 32'h0000_0007,
                                    32'h0000_0033, 32'h5555_5555, 32'hAAAA_AAAA, 32'h0BAD_0BAD};
   logic [11:0] rst_addr [0:7] = '{12'h300, 12'h301, 12'hF14, 12'h340, 12'hB00, 12'hB82,
                                   12'hC02, 12'h304};
   logic [31:0] rst_exp  [0:7] = '{32'h0000_1800, MISA, HART, 32'h0, 32'h0, 32'h0,
                                   32'h0, 32'h0};

   initial begin
      drive(1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 1'b0);
      tick();
      tick();
      check_en = 1'b1;

      // Ten cycles out of reset.
      drive(1'b1, 1'b0, 1'b0, 12'h0, 32'h0, 1'b0);
      repeat (10) tick();
      drive(1'b1, 1'b1, 1'b0, 12'hB00, 32'h0, 1'b0);
      peek();
      check("mcycle_after_10", csr_read_data, 32'd10);
      tick();
      drive(1'b1, 1'b1, 1'b0, 12'hB80, 32'h0, 1'b0);
      peek();
      check("mcycleh_after_10", csr_read_data, 32'd0);
      tick();

      // Low-word carry into high word.
      drive(1'b1, 1'b0, 1'b1, 12'hB00, 32'hFFFF_FFFF, 1'b0);
      tick();
      drive(1'b1, 1'b0, 1'b0, 12'h0, 32'h0, 1'b0);
      tick();
      drive(1'b1, 1'b1, 1'b0, 12'hB00, 32'h0, 1'b0);
      peek();
      check("mcycle_carry_lo", csr_read_data, 32'd0);
      tick();
      drive(1'b1, 1'b1, 1'b0, 12'hB80, 32'h0, 1'b0);
      peek();
      check("mcycle_carry_hi", csr_read_data, 32'd1);
      tick();

      // Full 64-bit wrap.
      drive(1'b1, 1'b0, 1'b1, 12'hB80, 32'hFFFF_FFFF, 1'b0);
      tick();
      drive(1'b1, 1'b0, 1'b1, 12'hB00, 32'hFFFF_FFFF, 1'b0);
      tick();
      drive(1'b1, 1'b0, 1'b0, 12'h0, 32'h0, 1'b0);
      tick();
      drive(1'b1, 1'b1, 1'b0, 12'hB00, 32'h0, 1'b0);
      peek();
      check("mcycle_wrap_lo", csr_read_data, 32'd0);
      tick();
      drive(1'b1, 1'b1, 1'b0, 12'hB80, 32'h0, 1'b0);
      peek();
      check("mcycle_wrap_hi", csr_read_data, 32'd0);
      tick();

      // mepc alignment and mstatus masking.
      drive(1'b1, 1'b0, 1'b1, 12'h341, 32'h8000_0003, 1'b0);
      tick();
      drive(1'b1, 1'b1, 1'b0, 12'h341, 32'h0, 1'b0);
      peek();
      check("mepc_bit0", csr_read_data, 32'h8000_0002);
      tick();
      drive(1'b1, 1'b0, 1'b1, 12'h300, 32'hFFFF_FFFF, 1'b0);
      tick();
      drive(1'b1, 1'b1, 1'b0, 12'h300, 32'h0, 1'b0);
      peek();
      check("mstatus_mask", csr_read_data, 32'h0000_1888);
      tick();

      // Read-only and unmapped accesses; misa write ignored silently.
      drive(1'b1, 1'b0, 1'b1, 12'hC00, 32'h0000_1234, 1'b0);
      peek();
      check("ro_write_illegal", {31'b0, illegal_access}, 32'd1);
      tick();
      drive(1'b1, 1'b1, 1'b0, 12'h7FF, 32'h0, 1'b0);
      peek();
      check("unmapped_illegal", {31'b0, illegal_access}, 32'd1);
      check("unmapped_data", csr_read_data, 32'h0);
      tick();
      drive(1'b1, 1'b0, 1'b1, 12'h301, 32'h0000_0000, 1'b0);
      peek();
      check("misa_write_legal", {31'b0, illegal_access}, 32'd0);
      tick();
      drive(1'b1, 1'b1, 1'b0, 12'h301, 32'h0, 1'b0);
      peek();
      check("misa_value", csr_read_data, 32'h4000_0100);
      tick();

      // Read-before-write on the same address.
      drive(1'b1, 1'b1, 1'b1, 12'h340, 32'hA5A5_A5A5, 1'b0);
      peek();
      check("rbw_old", csr_read_data, 32'h0);
      tick();
      drive(1'b1, 1'b1, 1'b0, 12'h340, 32'h0, 1'b0);
      peek();
      check("rbw_new", csr_read_data, 32'hA5A5_A5A5);
      tick();

      // minstret: write on the third of five retiring cycles wins.
      for (int i = 1; i <= 5; i++) begin
         if (i == 3) drive(1'b1, 1'b0, 1'b1, 12'hB02, 32'd100, 1'b1);
         else        drive(1'b1, 1'b0, 1'b0, 12'h0, 32'h0, 1'b1);
         tick();
      end
      drive(1'b1, 1'b1, 1'b0, 12'hB02, 32'h0, 1'b0);
      peek();
      check("minstret_write_prio", csr_read_data, 32'd102);
      tick();

      // Assorted writes and reads, checked by the model.
      for (int i = 0; i < 12; i++) begin
         drive(1'b1, 1'b0, 1'b1, seq_addr[i], seq_data[i], i[0]);
         tick();
         drive(1'b1, 1'b1, 1'b0, seq_addr[i], 32'h0, 1'b1);
         tick();
      end

      // Reset with a concurrent write: old value visible until the edge.
      drive(1'b1, 1'b0, 1'b1, 12'h340, 32'h1357_9BDF, 1'b0);
      tick();
      drive(1'b0, 1'b1, 1'b1, 12'h340, 32'hFFFF_0000, 1'b1);
      peek();
      check("pre_reset_read", csr_read_data, 32'h1357_9BDF);
      tick();
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, 1'b1, 1'b0, rst_addr[i], 32'h0, 1'b1);
         peek();
         check("post_reset_read", csr_read_data, rst_exp[i]);
         tick();
      end

      // First edge with reset released gives mcycle = 1.
      drive(1'b1, 1'b0, 1'b0, 12'h0, 32'h0, 1'b0);
      tick();
      drive(1'b1, 1'b1, 1'b0, 12'hC00, 32'h0, 1'b0);
      peek();
      check("first_increment", csr_read_data, 32'd1);
      tick();

      check_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
